// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared types and defaults for the two-master on-chip memory arbiter.
package onchip_memory_arbiter_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int DATA_W_DEF   = 32;
    localparam int BE_W_DEF     = DATA_W_DEF / 8;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// One Avalon-MM requester port; the arbiter takes the slave side.
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter_rr_hold_arbiter.sv
// Round-robin grant with a bounded hold: the last owner keeps the port for up
// to MAX_HOLD consecutive transfers while the other master is waiting.
module rr_hold_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       xfer_i,
    output logic [1:0] grant_o
);
    localparam int            CW       = hold_cnt_w(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    master_id_e    owner_q, owner_d, other, gntId;
    logic [CW-1:0] cnt_q, cnt_d;

    assign other = (owner_q == M0) ? M1 : M0;

    // Grants are forced off while reset is held so waitrequest rises immediately.
    always_comb begin
        grant_o = '0;
        gntId   = owner_q;
        if (reset_n) begin
            if (req_i[owner_q] && ((cnt_q < HOLD_MAX) || !req_i[other])) begin
                grant_o[owner_q] = 1'b1;
                gntId            = owner_q;
            end else if (req_i[other]) begin
                grant_o[other] = 1'b1;
                gntId          = other;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = '0;
        if (xfer_i) begin
            if (gntId == owner_q) begin
                cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                owner_d = gntId;
                cnt_d   = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= M0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares the single port of the on-chip memory between two Avalon-MM masters
// and steers the one-cycle-latency read return back to the issuing master.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BE_W     = BE_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    onchip_memory_arbiter_if.slave  m0,
    onchip_memory_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [BE_W-1:0]         mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [DATA_W-1:0]       mem_writedata,
    output logic                    mem_clken,
    input  logic [DATA_W-1:0]       mem_readdata
);
    logic [1:0] req, grant;
    logic       xfer, rdAccept;
    master_id_e gntId;
    logic       rdValid_q, rdValid_d;
    master_id_e rdOwner_q, rdOwner_d;

    assign req  = {m1.read | m1.write, m0.read | m0.write};
    assign xfer = |grant;

    rr_hold_arbiter #(.MAX_HOLD(MAX_HOLD)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (req),
        .xfer_i  (xfer),
        .grant_o (grant)
    );

    assign gntId = grant[1] ? M1 : M0;

    // Idle cycles present m0's signals; chipselect is what qualifies them.
    assign mem_address    = grant[1] ? m1.address    : m0.address;
    assign mem_byteenable = grant[1] ? m1.byteenable : m0.byteenable;
    assign mem_writedata  = grant[1] ? m1.writedata  : m0.writedata;
    assign mem_chipselect = xfer;
    assign mem_write      = (grant[0] & m0.write) | (grant[1] & m1.write);
    assign mem_clken      = reset_n;

    assign rdAccept = (grant[0] & m0.read & ~m0.write) | (grant[1] & m1.read & ~m1.write);

    assign m0.waitrequest   = ~grant[0];
    assign m1.waitrequest   = ~grant[1];
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rdValid_q & (rdOwner_q == M0);
    assign m1.readdatavalid = rdValid_q & (rdOwner_q == M1);

    always_comb begin
        rdValid_d = rdAccept;
        rdOwner_d = gntId;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdValid_q <= 1'b0;
            rdOwner_q <= M0;
        end else begin
            rdValid_q <= rdValid_d;
            rdOwner_q <= rdOwner_d;
        end
    end

    // A simultaneous read and write is serviced as a write; flag it in simulation.
    assert property (@(posedge clk) disable iff (!reset_n) !(m0.read && m0.write));
    assert property (@(posedge clk) disable iff (!reset_n) !(m1.read && m1.write));

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: behavioural memory, shadow memory and a
// read-return scoreboard, plus cycle-exact grant pattern checks.
module tb_onchip_memory_arbiter;
    import onchip_memory_arbiter_pkg::*;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic        owner;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [13:0] memAddress;
    logic [3:0]  memByteenable;
    logic        memChipselect, memWrite, memClken;
    logic [31:0] memWritedata;
    logic [31:0] memReaddata;

    logic [31:0] memArr [0:16383];
    logic [31:0] refMem [0:16383];
    sb_t         sbQ[$];
    int          cyc = 0;
    int          checkCount = 0;
    int          passCount = 0;

    onchip_memory_arbiter_if #(.ADDR_W(14), .DATA_W(32), .BE_W(4)) m0Bus ();
    onchip_memory_arbiter_if #(.ADDR_W(14), .DATA_W(32), .BE_W(4)) m1Bus ();

    onchip_memory_arbiter #(.ADDR_W(14), .DATA_W(32), .BE_W(4), .MAX_HOLD(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0Bus),
        .m1             (m1Bus),
        .mem_address    (memAddress),
        .mem_byteenable (memByteenable),
        .mem_chipselect (memChipselect),
        .mem_write      (memWrite),
        .mem_writedata  (memWritedata),
        .mem_clken      (memClken),
        .mem_readdata   (memReaddata)
    );

    always #5 clk = ~clk;

    // Registered-output memory: data for an address presented in N appears in N+1.
    always @(posedge clk) begin
        if (memClken && memChipselect) begin
            if (memWrite)
                for (int b = 0; b < 4; b++)
                    if (memByteenable[b]) memArr[memAddress][8*b +: 8] <= memWritedata[8*b +: 8];
            memReaddata <= memArr[memAddress];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic cmd_t mkCmd(input logic rd, input logic wr, input logic [13:0] addr,
                                   input logic [3:0] be, input logic [31:0] data);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.be = be; c.data = data;
        return c;
    endfunction

    function automatic cmd_t idleCmd();
        return mkCmd(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    endfunction

    task automatic driveBus(input cmd_t c0, input cmd_t c1);
        m0Bus.read = c0.rd; m0Bus.write = c0.wr; m0Bus.address = c0.addr;
        m0Bus.byteenable = c0.be; m0Bus.writedata = c0.data;
        m1Bus.read = c1.rd; m1Bus.write = c1.wr; m1Bus.address = c1.addr;
        m1Bus.byteenable = c1.be; m1Bus.writedata = c1.data;
    endtask

    task automatic applyStimulus(input cmd_t c0, input cmd_t c1);
        @(posedge clk);
        #1;
        driveBus(c0, c1);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wait"}, {m1Bus.waitrequest, m0Bus.waitrequest}, 2'b11);
        checkOutput({tag, "_rdv"}, {m1Bus.readdatavalid, m0Bus.readdatavalid}, 2'b00);
        checkOutput({tag, "_cs_wr"}, {memChipselect, memWrite}, 2'b00);
        checkOutput({tag, "_clken"}, memClken, 1'b0);
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        driveBus(idleCmd(), idleCmd());
        #1;
        checkResetValues("rst");
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Each cycle: retire the read accepted last cycle, then log this cycle's acceptances.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            checkOutput("rst_rdv_hold", {m1Bus.readdatavalid, m0Bus.readdatavalid}, 2'b00);
            sbQ.delete();
        end else begin
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc - 1) begin
                sb_t e;
                e = sbQ.pop_front();
                checkOutput("rdv_owner", {m1Bus.readdatavalid, m0Bus.readdatavalid}, e.owner ? 2'b10 : 2'b01);
                checkOutput("rd_data", e.owner ? m1Bus.readdata : m0Bus.readdata, e.data);
            end else begin
                checkOutput("rdv_idle", {m1Bus.readdatavalid, m0Bus.readdatavalid}, 2'b00);
            end
            if ((m0Bus.read || m0Bus.write) && !m0Bus.waitrequest) begin
                if (m0Bus.write) begin
                    for (int b = 0; b < 4; b++)
                        if (m0Bus.byteenable[b]) refMem[m0Bus.address][8*b +: 8] = m0Bus.writedata[8*b +: 8];
                end else sbQ.push_back('{cyc, 1'b0, refMem[m0Bus.address]});
            end
            if ((m1Bus.read || m1Bus.write) && !m1Bus.waitrequest) begin
                if (m1Bus.write) begin
                    for (int b = 0; b < 4; b++)
                        if (m1Bus.byteenable[b]) refMem[m1Bus.address][8*b +: 8] = m1Bus.writedata[8*b +: 8];
                end else sbQ.push_back('{cyc, 1'b1, refMem[m1Bus.address]});
            end
        end
    end

    initial begin
        driveBus(mkCmd(1'b0, 1'b1, 14'h5, 4'hF, 32'h1), mkCmd(1'b1, 1'b0, 14'h6, 4'hF, 32'h0));
        #1;
        reset_n = 1'b0;
        #2;
        checkResetValues("por");
        repeat (2) @(posedge clk);
        #1;
        driveBus(idleCmd(), idleCmd());
        reset_n = 1'b1;

        applyStimulus(mkCmd(1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF), idleCmd());
        checkOutput("wr_accept_m0", m0Bus.waitrequest, 1'b0);
        applyStimulus(idleCmd(), mkCmd(1'b1, 1'b0, 14'h0010, 4'h0, 32'h0));
        checkOutput("rd_accept_m1", m1Bus.waitrequest, 1'b0);
        applyStimulus(idleCmd(), idleCmd());
        checkOutput("raw_rdv", {m1Bus.readdatavalid, m0Bus.readdatavalid}, 2'b10);
        checkOutput("raw_data", m1Bus.readdata, 32'hDEADBEEF);

        applyStimulus(mkCmd(1'b0, 1'b1, 14'h0020, 4'hF, 32'h11223344), idleCmd());
        applyStimulus(mkCmd(1'b0, 1'b1, 14'h0020, 4'b0010, 32'h0000AB00), idleCmd());
        applyStimulus(mkCmd(1'b1, 1'b0, 14'h0020, 4'h0, 32'h0), idleCmd());
        applyStimulus(idleCmd(), idleCmd());
        checkOutput("be_merge", m0Bus.readdata, 32'h1122AB44);

        for (int i = 1; i <= 3; i++)
            applyStimulus(idleCmd(), mkCmd(1'b0, 1'b1, 14'(i), 4'hF, 32'hA0000000 | 32'(i)));
        applyStimulus(mkCmd(1'b1, 1'b0, 14'h0001, 4'h0, 32'h0), idleCmd());
        applyStimulus(idleCmd(), mkCmd(1'b1, 1'b0, 14'h0002, 4'h0, 32'h0));
        checkOutput("alt_rd1", {m0Bus.readdatavalid, m0Bus.readdata}, {1'b1, 32'hA0000001});
        applyStimulus(mkCmd(1'b1, 1'b0, 14'h0003, 4'h0, 32'h0), idleCmd());
        checkOutput("alt_rd2", {m1Bus.readdatavalid, m1Bus.readdata}, {1'b1, 32'hA0000002});
        applyStimulus(idleCmd(), idleCmd());
        checkOutput("alt_rd3", {m0Bus.readdatavalid, m0Bus.readdata}, {1'b1, 32'hA0000003});

        // Contention from a clean reset: eight grants each, starting with m0.
        doReset(2);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(mkCmd(1'b0, 1'b1, 14'(256 + i), 4'hF, 32'(i)),
                          mkCmd(1'b0, 1'b1, 14'(512 + i), 4'hF, 32'(i) ^ 32'hFFFF0000));
            checkOutput($sformatf("hold_grant_%0d", i), {m1Bus.waitrequest, m0Bus.waitrequest},
                        ((i / 8) % 2 == 0) ? 2'b10 : 2'b01);
        end

        doReset(2);
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i == 3) ? idleCmd() : mkCmd(1'b0, 1'b1, 14'h0300, 4'hF, 32'(i)),
                          mkCmd(1'b0, 1'b1, 14'h0301, 4'hF, 32'(i)));
            checkOutput($sformatf("drop_grant_%0d", i), {m1Bus.waitrequest, m0Bus.waitrequest},
                        (i < 3 || i == 11) ? 2'b10 : 2'b01);
        end

        applyStimulus(idleCmd(), mkCmd(1'b0, 1'b1, 14'h0030, 4'hF, 32'h55AA55AA));
        applyStimulus(idleCmd(), mkCmd(1'b1, 1'b0, 14'h0030, 4'h0, 32'h0));
        checkOutput("midrd_accept", m1Bus.waitrequest, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        driveBus(mkCmd(1'b0, 1'b1, 14'h0031, 4'hF, 32'h0), mkCmd(1'b1, 1'b0, 14'h0030, 4'h0, 32'h0));
        #1;
        checkResetValues("midrd");
        repeat (2) @(negedge clk);
        checkResetValues("midrd_held");
        @(posedge clk);
        #1;
        driveBus(idleCmd(), idleCmd());
        reset_n = 1'b1;
        applyStimulus(mkCmd(1'b1, 1'b0, 14'h0030, 4'h0, 32'h0), mkCmd(1'b1, 1'b0, 14'h0010, 4'h0, 32'h0));
        checkOutput("post_rst_grant", {m1Bus.waitrequest, m0Bus.waitrequest}, 2'b10);

        repeat (3) applyStimulus(idleCmd(), idleCmd());
        checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
